// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory controller:
// access sizes, controller states and the alignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        IDLE  = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input size_e size);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: merges store data into the old word and
// extracts/extends load data for byte, halfword and word accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;

    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        half_shift = {addr_lo[1], 4'b0000};
        byte_val   = old_word[byte_shift +: 8];
        half_val   = old_word[half_shift +: 16];
        store_word = old_word;
        load_value = 32'h0;
        misaligned = is_misaligned(addr_lo, size);

        case (size)
            SZ_BYTE: begin
                store_word[byte_shift +: 8] = wdata[7:0];
                load_value = {{24{is_signed & byte_val[7]}}, byte_val};
            end
            SZ_HALF: begin
                store_word[half_shift +: 16] = wdata[15:0];
                load_value = {{16{is_signed & half_val[15]}}, half_val};
            end
            SZ_WORD: begin
                store_word = wdata;
                load_value = old_word;
            end
            default: begin
                store_word = old_word;
                load_value = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with valid/ready handshake, configurable
// access latency, post-reset clear sweep and access error reporting.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state;
    state_e             next_state;
    logic [IDX_W-1:0]   clear_ptr;
    logic [LAT_W-1:0]   lat_cnt;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    size_e              size_q;
    logic               signed_q;
    logic [31:0]        wdata_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               init_done_q;

    logic [31:0]        mem [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [31:0]        mem_wdata;

    logic               accept;
    logic               do_access;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        old_word;
    logic [31:0]        store_word;
    logic [31:0]        load_value;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;

    assign accept       = req_valid && (state == IDLE);
    assign acc_idx      = addr_q[2 +: IDX_W];
    assign old_word     = mem[acc_idx];
    assign out_of_range = ((addr_q >> (IDX_W + 2)) != '0);
    assign acc_err      = misaligned || out_of_range || (size_q == SZ_ILLEGAL);

    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign init_done    = init_done_q;

    dmem_lane_align u_lane_align (
        .old_word   (old_word),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .store_word (store_word),
        .load_value (load_value),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        do_access  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clear_ptr;
        mem_wdata  = 32'h0;

        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clear_ptr == IDX_W'(DEPTH - 1)) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    do_access  = 1'b1;
                    next_state = RESP;
                    // Rejected stores leave the array untouched.
                    if (write_q && !acc_err) begin
                        mem_we    = 1'b1;
                        mem_waddr = acc_idx;
                        mem_wdata = store_word;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_ptr    <= '0;
            init_done_q  <= 1'b0;
            lat_cnt      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clear_ptr <= clear_ptr + 1'b1;
                if (clear_ptr == IDX_W'(DEPTH - 1)) begin
                    init_done_q <= 1'b1;
                end
            end
            if (accept) begin
                lat_cnt  <= LAT_W'(LATENCY - 1);
                write_q  <= req_write;
                addr_q   <= req_addr;
                size_q   <= size_e'(req_size);
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (do_access) begin
                resp_err_q   <= acc_err;
                resp_rdata_q <= (write_q || acc_err) ? 32'h0 : load_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: byte-array reference model,
// per-cycle response compare process and directed scenarios.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_done;

    int checks = 0;
    int passes = 0;

    logic [7:0]  model_bytes [DEPTH*4];
    logic        exp_pending = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH * 4; i++) model_bytes[i] = 8'h00;
    endtask

    // Memory viewed as a flat byte array; an access touches 1<<size bytes.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                input logic sg, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
             || (a >= 32'(DEPTH * 4));
        rd = 32'h0;
        if (!er) begin
            n = 1 << sz;
            if (w) begin
                for (int i = 0; i < n; i++) model_bytes[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = model_bytes[int'(a) + i];
                if (sg && n < 4 && v[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    // Whenever a response is presented it must match the model.
    always @(negedge clk) begin
        if (reset === 1'b1 && resp_valid === 1'b1) begin
            if (!exp_pending) begin
                checkOutput("unexpected resp_valid", 32'(resp_valid), 32'h0);
            end else begin
                checkOutput("resp_rdata", resp_rdata, exp_rdata);
                checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
                checkOutput("req_ready during resp", 32'(req_ready), 32'h0);
            end
        end
    end

    task automatic wait_init();
        int edges;
        edges = 0;
        while (init_done !== 1'b1 && edges < DEPTH + 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) checkOutput("req_ready during clear", 32'(req_ready), 32'h0);
        end
        checkOutput("clear sweep cycles", 32'(edges), 32'(DEPTH));
        checkOutput("req_ready after clear", 32'(req_ready), 32'h1);
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] wd, input int hold,
                                 output logic [31:0] rd, output logic er);
        int edges;
        logic [31:0] first;
        logic [31:0] mrd;
        logic        mer;
        model_access(w, a, sz, sg, wd, mrd, mer);
        @(negedge clk);
        edges = 0;
        while (req_ready !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("req_ready before request", 32'(req_ready), 32'h1);
        exp_rdata   = mrd;
        exp_err     = mer;
        exp_pending = 1'b1;
        req_valid   = 1'b1;
        req_write   = w;
        req_addr    = a;
        req_size    = sz;
        req_signed  = sg;
        req_wdata   = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 0;
        while (resp_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("response latency", 32'(edges), 32'(LAT));
        first = resp_rdata;
        rd    = resp_rdata;
        er    = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("resp_valid held", 32'(resp_valid), 32'h1);
            checkOutput("resp_rdata stable", resp_rdata, first);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready  = 1'b0;
        exp_pending = 1'b0;
        checkOutput("resp_valid after accept", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        // Reset and clear sweep
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset resp_err", 32'(resp_err), 32'h0);
        checkOutput("reset init_done", 32'(init_done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        wait_init();

        applyStimulus(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("load 0x3FC after clear", rd, 32'h0000_0000);
        checkOutput("load 0x3FC err", 32'(er), 32'h0);

        // Byte merge into a word; upper wdata bits must be ignored
        applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er);
        applyStimulus(1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA55, 0, rd, er);
        checkOutput("byte store rdata", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("word load 0x10", rd, 32'hDEAD55EF);

        applyStimulus(1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 0, rd, er);
        checkOutput("signed byte 0x10", rd, 32'hFFFFFFEF);
        applyStimulus(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, rd, er);
        checkOutput("unsigned half 0x12", rd, 32'h0000DEAD);
        applyStimulus(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0, rd, er);
        checkOutput("signed half 0x12", rd, 32'hFFFFDEAD);
        applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er);
        checkOutput("unsigned byte 0x13", rd, 32'h000000DE);
        applyStimulus(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 0, rd, er);
        checkOutput("signed half positive", rd, 32'h000055EF);
        applyStimulus(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 0, rd, er);
        checkOutput("signed word ignores sign", rd, 32'hDEAD55EF);

        // Error cases leave memory unchanged
        applyStimulus(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 0, rd, er);
        checkOutput("misaligned half err", 32'(er), 32'h1);
        checkOutput("misaligned half rdata", rd, 32'h0);
        applyStimulus(1'b1, 32'h402, 2'b10, 1'b0, 32'h11223344, 0, rd, er);
        checkOutput("store 0x402 err", 32'(er), 32'h1);
        applyStimulus(1'b1, 32'h400, 2'b10, 1'b0, 32'h11223344, 0, rd, er);
        checkOutput("store 0x400 out of range err", 32'(er), 32'h1);
        applyStimulus(1'b1, 32'h10, 2'b11, 1'b0, 32'h11223344, 0, rd, er);
        checkOutput("illegal size err", 32'(er), 32'h1);
        applyStimulus(1'b0, 32'h13, 2'b11, 1'b1, 32'h0, 0, rd, er);
        checkOutput("illegal size load rdata", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("0x10 unchanged", rd, 32'hDEAD55EF);
        applyStimulus(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("0x0 unchanged", rd, 32'h0);

        // Backpressure on the response
        applyStimulus(1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 5, rd, er);
        checkOutput("held signed byte", rd, 32'hFFFFFFEF);

        // Reset during the wait phase of a store
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_pending = 1'b0;
        #1;
        checkOutput("mid-op reset resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("mid-op reset req_ready", 32'(req_ready), 32'h0);
        checkOutput("mid-op reset init_done", 32'(init_done), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        wait_init();
        applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("load 0x20 after abort", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        checkOutput("0x10 cleared by sweep", rd, 32'h0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
